button_conditioner: RTL and testbench

//  Upstream input stage for state_controller and other logic driven by the board push-buttons.
//  - Synchronises NUM_BTN raw active-low buttons into clk.
//  - Debounces each button independently.
//  - Presents for each button:
//    - a clean active-high level
//    - a single-cycle press strobe
//    - a single-cycle release strobe

---
 rtl/button_conditioner.sv | 125 ++++++++++++
 tb/tb_button_conditioner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: synchronises raw active-low buttons, debounces each one
// independently and presents a clean level plus single-cycle press/release strobes.
module button_conditioner #(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic               clk,
  input  logic               but_rst,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync1_n;
  logic [NUM_BTN-1:0] sync2_n;
  logic [NUM_BTN-1:0] pressed;

  state_t             state     [NUM_BTN];
  state_t             state_nxt [NUM_BTN];
  logic [CNT_W-1:0]   cnt       [NUM_BTN];
  logic [CNT_W-1:0]   cnt_nxt   [NUM_BTN];
  logic [NUM_BTN-1:0] level_nxt;
  logic [NUM_BTN-1:0] press_nxt;
  logic [NUM_BTN-1:0] release_nxt;

  // Synchroniser kept in raw polarity so reset leaves it at the idle-high level.
  always_ff @(posedge clk or negedge but_rst) begin
    if (!but_rst) begin
      sync1_n <= '1;
      sync2_n <= '1;
    end else begin
      sync1_n <= btn_n;
      sync2_n <= sync1_n;
    end
  end

  assign pressed = ~sync2_n;

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      state_nxt[i]   = state[i];
      cnt_nxt[i]     = cnt[i];
      press_nxt[i]   = 1'b0;
      release_nxt[i] = 1'b0;

      case (state[i])
        RELEASED: begin
          if (pressed[i]) begin
            state_nxt[i] = PRESS_PEND;
            cnt_nxt[i]   = '0;
          end
        end
        PRESS_PEND: begin
          if (!pressed[i]) begin
            state_nxt[i] = RELEASED;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == CNT_MAX) begin
            state_nxt[i] = PRESSED;
            cnt_nxt[i]   = '0;
            press_nxt[i] = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!pressed[i]) begin
            state_nxt[i] = RELEASE_PEND;
            cnt_nxt[i]   = '0;
          end
        end
        RELEASE_PEND: begin
          if (pressed[i]) begin
            state_nxt[i] = PRESSED;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == CNT_MAX) begin
            state_nxt[i]   = RELEASED;
            cnt_nxt[i]     = '0;
            release_nxt[i] = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          state_nxt[i] = RELEASED;
          cnt_nxt[i]   = '0;
        end
      endcase

      level_nxt[i] = (state_nxt[i] == PRESSED) || (state_nxt[i] == RELEASE_PEND);
    end
  end

  // Outputs are registered from the next-state decode so they move with the state.
  always_ff @(posedge clk or negedge but_rst) begin
    if (!but_rst) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i] <= RELEASED;
        cnt[i]   <= '0;
      end
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: a window-based debounce model checked
// every cycle, plus hand-computed checkpoints for each directed scenario.
module tb_button_conditioner;

  localparam int NUM_BTN = 3;
  localparam int DEB     = 4;

  logic               clk;
  logic               but_rst;
  logic [NUM_BTN-1:0] btn_n;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  int compared   = 0;
  int mismatched = 0;

  button_conditioner #(
    .NUM_BTN        (NUM_BTN),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk        (clk),
    .but_rst    (but_rst),
    .btn_n      (btn_n),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the debounced level flips once the last DEB+1 samples the debouncer has
  // seen all disagree with it; samples reach the debouncer two edges after capture.
  logic [NUM_BTN-1:0] pipe_q [$];
  logic [NUM_BTN-1:0] seen_q [$];
  logic [NUM_BTN-1:0] m_level;
  logic [NUM_BTN-1:0] m_press;
  logic [NUM_BTN-1:0] m_release;
  bit                 model_valid = 0;

  task automatic compareOne(input string name, input logic [NUM_BTN-1:0] act,
                            input logic [NUM_BTN-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: actual=%b required=%b", name, $time, act, req);
    end
  endtask

  initial begin
    logic [NUM_BTN-1:0] raw;
    logic               rst_now;
    logic [NUM_BTN-1:0] seen;
    bit                 all_diff;
    forever begin
      @(posedge clk);
      raw     = ~btn_n;
      rst_now = but_rst;
      #2;
      if (!rst_now) begin
        pipe_q      = {};
        pipe_q.push_back('0);
        pipe_q.push_back('0);
        seen_q      = {};
        m_level     = '0;
        m_press     = '0;
        m_release   = '0;
        model_valid = 1;
      end else if (model_valid) begin
        pipe_q.push_back(raw);
        seen = pipe_q.pop_front();
        seen_q.push_back(seen);
        if (seen_q.size() > DEB + 1) void'(seen_q.pop_front());
        m_press   = '0;
        m_release = '0;
        if (seen_q.size() == DEB + 1) begin
          for (int i = 0; i < NUM_BTN; i++) begin
            all_diff = 1;
            for (int k = 0; k < seen_q.size(); k++)
              if (seen_q[k][i] == m_level[i]) all_diff = 0;
            if (all_diff) begin
              if (m_level[i]) m_release[i] = 1'b1;
              else            m_press[i]   = 1'b1;
              m_level[i] = ~m_level[i];
            end
          end
        end
      end
      if (model_valid) begin
        compareOne("model_level", btn_level, m_level);
        compareOne("model_press", btn_press, m_press);
        compareOne("model_release", btn_release, m_release);
        compareOne("strobe_overlap", btn_press & btn_release, '0);
      end
    end
  end

  task automatic applyStimulus(input logic [NUM_BTN-1:0] value);
    @(negedge clk);
    btn_n = value;
  endtask

  task automatic holdStimulus(input logic [NUM_BTN-1:0] value, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      btn_n = value;
    end
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic checkOutput(input string name, input logic [NUM_BTN-1:0] lvl,
                             input logic [NUM_BTN-1:0] prs, input logic [NUM_BTN-1:0] rel);
    compareOne({name, "_level"}, btn_level, lvl);
    compareOne({name, "_press"}, btn_press, prs);
    compareOne({name, "_release"}, btn_release, rel);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    but_rst = 1'b0;
    btn_n   = '1;

    // Reset with buttons idle, then run quietly.
    repeat (3) @(negedge clk);
    checkOutput("reset", 3'b000, 3'b000, 3'b000);
    @(negedge clk);
    but_rst = 1'b1;
    waitEdges(20);
    checkOutput("idle", 3'b000, 3'b000, 3'b000);

    // Clean press of button 0.
    applyStimulus(3'b110);
    waitEdges(6);
    checkOutput("press0_early", 3'b000, 3'b000, 3'b000);
    waitEdges(1);
    checkOutput("press0", 3'b001, 3'b001, 3'b000);
    waitEdges(1);
    checkOutput("press0_after", 3'b001, 3'b000, 3'b000);

    // Button 1 bounces every 2 cycles, then settles low.
    for (int k = 0; k < 5; k++) begin
      holdStimulus(3'b100, 2);
      holdStimulus(3'b110, 2);
    end
    applyStimulus(3'b100);
    waitEdges(6);
    checkOutput("press1_early", 3'b001, 3'b000, 3'b000);
    waitEdges(1);
    checkOutput("press1", 3'b011, 3'b010, 3'b000);
    waitEdges(1);
    checkOutput("press1_after", 3'b011, 3'b000, 3'b000);

    // Release button 0 with bounce.
    holdStimulus(3'b101, 1);
    holdStimulus(3'b100, 1);
    holdStimulus(3'b101, 1);
    holdStimulus(3'b100, 1);
    applyStimulus(3'b101);
    waitEdges(6);
    checkOutput("release0_early", 3'b011, 3'b000, 3'b000);
    waitEdges(1);
    checkOutput("release0", 3'b010, 3'b000, 3'b001);
    waitEdges(1);
    checkOutput("release0_after", 3'b010, 3'b000, 3'b000);

    // Clean release of button 1.
    applyStimulus(3'b111);
    waitEdges(7);
    checkOutput("release1", 3'b000, 3'b000, 3'b010);
    waitEdges(3);

    // Buttons 0 and 2 together.
    applyStimulus(3'b010);
    waitEdges(6);
    checkOutput("press02_early", 3'b000, 3'b000, 3'b000);
    waitEdges(1);
    checkOutput("press02", 3'b101, 3'b101, 3'b000);
    waitEdges(1);
    checkOutput("press02_after", 3'b101, 3'b000, 3'b000);

    // Reset while button 1 is mid-qualification; all stay held through release.
    applyStimulus(3'b000);
    waitEdges(5);
    @(negedge clk);
    but_rst = 1'b0;
    #1;
    checkOutput("reset_mid", 3'b000, 3'b000, 3'b000);
    waitEdges(2);
    @(negedge clk);
    but_rst = 1'b1;
    waitEdges(6);
    checkOutput("requal_early", 3'b000, 3'b000, 3'b000);
    waitEdges(1);
    checkOutput("requal", 3'b111, 3'b111, 3'b000);
    waitEdges(1);
    checkOutput("requal_after", 3'b111, 3'b000, 3'b000);

    // Release everything.
    applyStimulus(3'b111);
    waitEdges(7);
    checkOutput("release_all", 3'b000, 3'b000, 3'b111);
    waitEdges(5);
    checkOutput("final", 3'b000, 3'b000, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
